// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache, the D-cache and the shared line memory.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface mem_arbiter_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
);
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_ack;
  logic [LINE_W-1:0]    i_rdata;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [LINE_W-1:0]    d_wdata;
  logic                 d_ack;
  logic [LINE_W-1:0]    d_rdata;
  logic                 m_readM;
  logic                 m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic [LINE_W-1:0]    m_wdata;
  logic [LINE_W-1:0]    m_rdata;
  logic                 m_ready;
  logic                 busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_ack, i_rdata, d_ack, d_rdata, m_readM, m_writeM, m_address, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, m_readM, m_writeM, m_address, m_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port line arbiter: D side has priority, a starvation counter forces an
// I grant after STARVE_LIMIT consecutive D grants while I is waiting.
module mem_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int LINE_WORDS   = 4,
  parameter int STARVE_LIMIT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]     LIMIT      = CNT_W'(STARVE_LIMIT);
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     starve_cnt, cnt_n;
  logic                 grant, grant_d;
  logic                 owner_d;
  logic                 m_readM, m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic [LINE_W-1:0]    m_wdata;
  logic [LINE_W-1:0]    i_rdata, d_rdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LIMIT) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = starve_cnt;
    grant   = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant   = 1'b1;
          grant_d = bus.d_req && !(bus.i_req && starve_cnt == LIMIT);
          cnt_n   = (grant_d && bus.i_req) ? sat_inc(starve_cnt) : '0;
          state_n = BUSY;
        end
      end
      BUSY:    if (bus.m_ready) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= cnt_n;
    end
  end

  // Grant edge latches the winning request onto the memory bus; completion edge clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_d   <= 1'b0;
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else if (grant) begin
      owner_d   <= grant_d;
      m_readM   <= !(grant_d && bus.d_we);
      m_writeM  <= grant_d && bus.d_we;
      m_address <= (grant_d ? bus.d_addr : bus.i_addr) & ALIGN_MASK;
      m_wdata   <= grant_d ? bus.d_wdata : '0;
    end else if (state == BUSY && bus.m_ready) begin
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      if (m_readM) begin
        if (owner_d) d_rdata <= bus.m_rdata;
        else         i_rdata <= bus.m_rdata;
      end
    end
  end

  assign bus.i_ack     = (state == RESP) && !owner_d;
  assign bus.d_ack     = (state == RESP) && owner_d;
  assign bus.busy      = (state != IDLE);
  assign bus.m_readM   = m_readM;
  assign bus.m_writeM  = m_writeM;
  assign bus.m_address = m_address;
  assign bus.m_wdata   = m_wdata;
  assign bus.i_rdata   = i_rdata;
  assign bus.d_rdata   = d_rdata;
endmodule
